siteswap_decoder: RTL and testbench

//  Inverse of the trajectory path: consumes per-frame tracked ball positions and recovers the siteswap.

---
 rtl/siteswap_decoder.sv | 171 +++++++++++++++++
 tb/tb_siteswap_decoder.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siteswap_decoder.sv
// siteswap_decoder: recovers siteswap throws from per-frame ball positions.
// One ball is scanned per cycle; each catch is divided into beats and emitted.
module siteswap_decoder #(
   parameter int LIFT       = 16,
   parameter int CATCH      = 8,
   parameter int MIN_FLIGHT = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        nf_in,
   input  logic [10:0] ball_x_in [6:0],
   input  logic [9:0]  ball_y_in [6:0],
   input  logic        ball_valid_in,
   input  logic [2:0]  num_balls,
   input  logic [10:0] hand_x_in [1:0],
   input  logic [9:0]  hand_y_in,
   input  logic [14:0] frame_per_beat,
   input  logic        throw_ready_in,
   output logic        throw_valid_out,
   output logic [2:0]  throw_ball_out,
   output logic        throw_hand_out,
   output logic [2:0]  throw_out,
   output logic [11:0] throw_t_out,
   output logic        throw_sat_out,
   output logic        overrun_out
);

   typedef enum logic [2:0] {
      IDLE, CAPTURE, SCAN, DIVIDE, EMIT
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] t_q, tf_q;
   logic [10:0] x_q [6:0];
   logic [9:0]  y_q [6:0];
   logic [2:0]  nb_q, i_q;
   logic [14:0] fpb_q;
   logic [10:0] mid_q;
   logic [6:0]  fly_q, hand_q;
   logic [11:0] launch_q [6:0];
   logic [15:0] rem_q;
   logic [3:0]  q_q;

   logic [11:0] mid_sum, flight;
   logic [10:0] y_ext, hy_ext;
   logic        rise, land, active, keep, last;
   logic        div_c, sub_ok;
   logic [15:0] half;

   always_comb begin
      mid_sum = {1'b0, hand_x_in[0]} + {1'b0, hand_x_in[1]};
      y_ext   = {1'b0, y_q[i_q]};
      hy_ext  = {1'b0, hand_y_in};
      rise    = (y_ext + 11'(LIFT)) < hy_ext;
      land    = (y_ext + 11'(CATCH)) >= hy_ext;
      flight  = tf_q - launch_q[i_q];
      active  = i_q < nb_q;
      keep    = flight >= 12'(MIN_FLIGHT);
      last    = i_q == 3'd6;
      div_c   = active && fly_q[i_q] && land && keep;
      sub_ok  = (rem_q >= {1'b0, fpb_q}) && !q_q[3];
      half    = {2'b0, fpb_q[14:1]};
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (nf_in && ball_valid_in) state_d = CAPTURE;
         CAPTURE: state_d = SCAN;
         SCAN: begin
            if (div_c)     state_d = DIVIDE;
            else if (last) state_d = IDLE;
         end
         DIVIDE:  if (!sub_ok) state_d = EMIT;
         EMIT: begin
            if (throw_ready_in) state_d = last ? IDLE : SCAN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         t_q             <= '0;
         tf_q            <= '0;
         nb_q            <= '0;
         i_q             <= '0;
         fpb_q           <= '0;
         mid_q           <= '0;
         fly_q           <= '0;
         hand_q          <= '0;
         rem_q           <= '0;
         q_q             <= '0;
         throw_valid_out <= 1'b0;
         throw_ball_out  <= '0;
         throw_hand_out  <= 1'b0;
         throw_out       <= '0;
         throw_t_out     <= '0;
         throw_sat_out   <= 1'b0;
         overrun_out     <= 1'b0;
         for (int k = 0; k < 7; k++) begin
            x_q[k]      <= '0;
            y_q[k]      <= '0;
            launch_q[k] <= '0;
         end
      end else begin
         t_q         <= t_q + 12'(nf_in);
         overrun_out <= nf_in && (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (nf_in && ball_valid_in) begin
                  x_q   <= ball_x_in;
                  y_q   <= ball_y_in;
                  nb_q  <= num_balls;
                  fpb_q <= frame_per_beat;
                  mid_q <= mid_sum[11:1];
                  tf_q  <= t_q;
               end
            end
            CAPTURE: i_q <= '0;
            SCAN: begin
               if (!active) begin
                  fly_q[i_q] <= 1'b0;
               end else if (!fly_q[i_q]) begin
                  if (rise) begin
                     fly_q[i_q]    <= 1'b1;
                     launch_q[i_q] <= tf_q;
                     hand_q[i_q]   <= x_q[i_q] >= mid_q;
                  end
               end else if (land) begin
                  fly_q[i_q] <= 1'b0;
               end
               if (div_c) begin
                  rem_q <= {4'b0, flight} + half;
                  q_q   <= '0;
               end else if (!last) begin
                  i_q <= i_q + 3'd1;
               end
            end
            DIVIDE: begin
               if (sub_ok) begin
                  rem_q <= rem_q - {1'b0, fpb_q};
                  q_q   <= q_q + 4'd1;
               end else begin
                  throw_valid_out <= 1'b1;
                  throw_ball_out  <= i_q;
                  throw_hand_out  <= hand_q[i_q];
                  throw_t_out     <= launch_q[i_q];
                  throw_sat_out   <= q_q[3];
                  // zero beats still reads as the minimum throw
                  throw_out <= q_q[3] ? 3'd7 :
                               (q_q == 4'd0) ? 3'd1 : q_q[2:0];
               end
            end
            EMIT: begin
               if (throw_ready_in) begin
                  throw_valid_out <= 1'b0;
                  if (!last) i_q <= i_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_siteswap_decoder.sv
// tb_siteswap_decoder: directed scenarios plus a randomized run
// compared against a frame-level throw model.
module tb_siteswap_decoder;

   logic        clk = 1'b0;
   logic        rst_n, nf, bv, rdy;
   logic [10:0] bx [6:0];
   logic [9:0]  by [6:0];
   logic [2:0]  nb;
   logic [10:0] hx [1:0];
   logic [9:0]  hy;
   logic [14:0] fpb;
   logic        vld, thand, tsat, ovr;
   logic [2:0]  tball, tval;
   logic [11:0] tt;
   logic [20:0] obs;

   int checks = 0;
   int errors = 0;
   int frame_no = 0;

   typedef struct {
      int ball; int hand; int val; int t; int sat;
   } ev_t;
   ev_t expq[$];

   always #5 clk = ~clk;

   assign obs = {vld, tball, thand, tval, tt, tsat};

   siteswap_decoder dut (
      .clk_in(clk), .rst_in(rst_n), .nf_in(nf),
      .ball_x_in(bx), .ball_y_in(by),
      .ball_valid_in(bv), .num_balls(nb),
      .hand_x_in(hx), .hand_y_in(hy),
      .frame_per_beat(fpb),
      .throw_ready_in(rdy),
      .throw_valid_out(vld), .throw_ball_out(tball),
      .throw_hand_out(thand), .throw_out(tval),
      .throw_t_out(tt), .throw_sat_out(tsat),
      .overrun_out(ovr)
   );

   function automatic logic [20:0] ev(int b, int h, int v, int t, int s);
      return {1'b1, 3'(b), 1'(h), 3'(v), 12'(t), 1'(s)};
   endfunction

   function automatic logic [9:0] yv(int v);
      return 10'(v);
   endfunction

   task automatic pulse(input logic v);
      @(negedge clk);
      nf = 1'b1;
      bv = v;
      @(negedge clk);
      nf = 1'b0;
      frame_no++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input int maxc, output int cnt);
      cnt = 0;
      while (!vld && cnt < maxc) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      nf = 1'b0; bv = 1'b0; rdy = 1'b1;
      nb = '0; fpb = 15'd10; hy = 10'd400;
      hx[0] = '0; hx[1] = '0;
      for (int k = 0; k < 7; k++) begin
         bx[k] = '0;
         by[k] = hy;
      end
      idle(3);
      rst_n = 1'b1;
      frame_no = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL reset_out: got %h want 0", obs);
      end
      checks++;
      if (ovr !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovr: got %b want 0", ovr);
      end
   endtask

   task automatic test_basic();
      int cnt;
      do_reset();
      fpb = 15'd10; nb = 3'd1;
      hx[0] = 11'd100; hx[1] = 11'd300; bx[0] = 11'd50;
      for (int f = 0; f < 35; f++) begin
         by[0] = (f >= 5) ? yv(400 - 17) : hy;
         pulse(1'b1);
         idle(10);
      end
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 0, 3, 5, 0)) begin
         errors++;
         $display("FAIL basic_event: got %h want %h",
                  obs, ev(0, 0, 3, 5, 0));
      end
      checks++;
      if (cnt != 6) begin
         errors++;
         $display("FAIL basic_latency: got %0d want 6", cnt);
      end
      @(negedge clk);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL basic_drop: got %b want 0", vld);
      end
      wait_valid(20, cnt);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL basic_extra: got %b want 0", vld);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      do_reset();
      fpb = 15'd4; nb = 3'd5; hy = 10'd500;
      hx[0] = 11'd600; hx[1] = 11'd200;
      for (int k = 0; k < 7; k++) by[k] = hy;
      bx[1] = 11'd100; bx[4] = 11'd400;
      pulse(1'b1); idle(10);
      by[1] = yv(500 - 17); by[4] = yv(500 - 17);
      for (int f = 1; f < 10; f++) begin
         pulse(1'b1); idle(10);
      end
      by[1] = hy; by[4] = hy;
      rdy = 1'b0;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(1, 0, 2, 1, 0)) begin
         errors++;
         $display("FAIL b2b_first: got %h want %h",
                  obs, ev(1, 0, 2, 1, 0));
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== ev(1, 0, 2, 1, 0)) begin
            errors++;
            $display("FAIL b2b_hold: got %h want %h",
                     obs, ev(1, 0, 2, 1, 0));
         end
      end
      rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drop: got %b want 0", vld);
      end
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(4, 1, 2, 1, 0)) begin
         errors++;
         $display("FAIL b2b_second: got %h want %h",
                  obs, ev(4, 1, 2, 1, 0));
      end
      @(negedge clk);
      wait_valid(20, cnt);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL b2b_extra: got %b want 0", vld);
      end
   endtask

   task automatic test_wrap();
      int cnt;
      do_reset();
      fpb = 15'd10; nb = 3'd1;
      hx[0] = 11'd100; hx[1] = 11'd300; bx[0] = 11'd50;
      while (frame_no < 4090) pulse(1'b0);
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      while (frame_no < 4110) pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 0, 2, 4090, 0)) begin
         errors++;
         $display("FAIL wrap_event: got %h want %h",
                  obs, ev(0, 0, 2, 4090, 0));
      end
      idle(2);
   endtask

   task automatic test_saturate();
      int cnt;
      do_reset();
      fpb = 15'd10; nb = 3'd1;
      hx[0] = 11'd100; hx[1] = 11'd300; bx[0] = 11'd50;
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      while (frame_no < 200) pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 0, 7, 0, 1)) begin
         errors++;
         $display("FAIL sat_event: got %h want %h",
                  obs, ev(0, 0, 7, 0, 1));
      end
      checks++;
      if (cnt != 11) begin
         errors++;
         $display("FAIL sat_latency: got %0d want 11", cnt);
      end
      idle(5);
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(30, cnt);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL short_flight: got %b want 0", vld);
      end
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      pulse(1'b0); pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 0, 1, 204, 0) || cnt != 3) begin
         errors++;
         $display("FAIL min_throw: got %h/%0d want %h/3",
                  obs, cnt, ev(0, 0, 1, 204, 0));
      end
      idle(3);
   endtask

   task automatic test_overrun();
      int cnt;
      do_reset();
      fpb = 15'd5; nb = 3'd1;
      hx[0] = 11'd0; hx[1] = 11'd2000; bx[0] = 11'd1500;
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      while (frame_no < 10) pulse(1'b0);
      rdy = 1'b0;
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      by[0] = yv(400 - 17);
      pulse(1'b1);
      checks++;
      if (ovr !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse: got %b want 1", ovr);
      end
      @(negedge clk);
      checks++;
      if (ovr !== 1'b0 || obs !== ev(0, 1, 2, 0, 0)) begin
         errors++;
         $display("FAIL ovr_held: got %b/%h want 0/%h",
                  ovr, obs, ev(0, 1, 2, 0, 0));
      end
      rdy = 1'b1;
      @(negedge clk);
      idle(20);
      pulse(1'b1); idle(10);
      while (frame_no < 18) pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 1, 1, 12, 0)) begin
         errors++;
         $display("FAIL ovr_next: got %h want %h",
                  obs, ev(0, 1, 1, 12, 0));
      end
      idle(3);
   endtask

   task automatic test_reset_mid();
      int cnt;
      do_reset();
      fpb = 15'd10; nb = 3'd3;
      hx[0] = 11'd100; hx[1] = 11'd300;
      for (int k = 0; k < 7; k++) bx[k] = 11'd50;
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      by[2] = yv(400 - 17);
      pulse(1'b1); idle(10);
      while (frame_no < 200) pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      idle(3);
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 21'd0 || ovr !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_out: got %h want 0", obs);
      end
      idle(2);
      rst_n = 1'b1;
      frame_no = 0;
      wait_valid(30, cnt);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL rst_lost: got %b want 0", vld);
      end
      by[2] = yv(400 - 12);
      for (int f = 0; f < 5; f++) begin
         pulse(1'b1); idle(10);
      end
      by[2] = hy;
      pulse(1'b1);
      wait_valid(30, cnt);
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL rst_in_hand: got %h want 0", obs);
      end
      fpb = 15'd3;
      by[0] = yv(400 - 17);
      pulse(1'b1); idle(10);
      while (frame_no < 12) pulse(1'b0);
      by[0] = hy;
      pulse(1'b1);
      wait_valid(40, cnt);
      checks++;
      if (obs !== ev(0, 0, 2, 6, 0)) begin
         errors++;
         $display("FAIL rst_t_zero: got %h want %h",
                  obs, ev(0, 0, 2, 6, 0));
      end
      idle(3);
   endtask

   task automatic test_random();
      int m_fly [7];
      int m_launch [7];
      int m_hand [7];
      int mode [7];
      int hyi, mid, fl, b;
      logic [20:0] hold_v, want;
      bit held;
      ev_t e;
      do_reset();
      hyi = 300 + int'($urandom_range(0, 399));
      hy = yv(hyi);
      nb = 3'd7;
      for (int k = 0; k < 7; k++) begin
         m_fly[k] = 0; m_launch[k] = 0; m_hand[k] = 0;
         mode[k] = 2;
      end
      held = 1'b0;
      hold_v = '0;
      repeat (150) begin
         if ($urandom_range(0, 7) == 0) nb = 3'($urandom_range(0, 7));
         fpb = 15'($urandom_range(1, 12));
         hx[0] = 11'($urandom_range(0, 2047));
         hx[1] = 11'($urandom_range(0, 2047));
         bv = ($urandom_range(0, 9) != 0);
         for (int k = 0; k < 7; k++) begin
            if ($urandom_range(0, 5) == 0) mode[k] = $urandom_range(0, 2);
            bx[k] = 11'($urandom_range(0, 2047));
            case (mode[k])
               0:       by[k] = yv(hyi - 17 - int'($urandom_range(0, 29)));
               1:       by[k] = yv(hyi - 16 + int'($urandom_range(0, 7)));
               default: by[k] = yv(hyi - 8 + int'($urandom_range(0, 3)));
            endcase
         end
         if (bv) begin
            mid = (int'(hx[0]) + int'(hx[1])) / 2;
            for (int k = 0; k < 7; k++) begin
               if (k >= int'(nb)) begin
                  m_fly[k] = 0;
               end else if (m_fly[k] == 0) begin
                  if (int'(by[k]) + 16 < hyi) begin
                     m_fly[k] = 1;
                     m_launch[k] = frame_no;
                     m_hand[k] = (int'(bx[k]) >= mid) ? 1 : 0;
                  end
               end else if (int'(by[k]) + 8 >= hyi) begin
                  m_fly[k] = 0;
                  fl = (frame_no - m_launch[k]) % 4096;
                  if (fl >= 3) begin
                     b = (fl + int'(fpb) / 2) / int'(fpb);
                     e.ball = k;
                     e.hand = m_hand[k];
                     e.val = (b > 7) ? 7 : ((b == 0) ? 1 : b);
                     e.t = m_launch[k] % 4096;
                     e.sat = (b > 7) ? 1 : 0;
                     expq.push_back(e);
                  end
               end
            end
         end
         pulse(bv);
         for (int c = 0; c < 200; c++) begin
            rdy = (c >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (held) begin
               checks++;
               if (obs !== hold_v) begin
                  errors++;
                  $display("FAIL rnd_hold: got %h want %h", obs, hold_v);
               end
            end
            if (vld && rdy) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL rnd_unexpected: got %h want none", obs);
               end else begin
                  e = expq.pop_front();
                  want = ev(e.ball, e.hand, e.val, e.t, e.sat);
                  if (obs !== want) begin
                     errors++;
                     $display("FAIL rnd_event: got %h want %h", obs, want);
                  end
               end
            end
            held = vld && !rdy;
            hold_v = obs;
            @(negedge clk);
         end
         checks++;
         if (expq.size() != 0) begin
            errors++;
            $display("FAIL rnd_missing: got %0d left want 0",
                     expq.size());
            expq.delete();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_saturate();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
